// File: rtl/bash_hash_host_if.sv
// Purpose : host-side bundle for bash_hash_host. It carries the command, the X/Y word streams, status and the register-map bus.
// Latency : wires only. The DUT uses the slave modport and the driver/bench uses the master modport.
// Backpress: in and out streams use valid/ready. cmd uses valid/ready. The register bus has no stall.
interface bash_hash_host_if #(
  parameter int XLEN    = 32,
  parameter int ADDRLEN = 8
);
  // command
  logic               cmd_valid_i;
  logic               cmd_ready_o;
  logic [XLEN-1:0]    cmd_l_i;
  // X word stream into the host
  logic               in_valid_i;
  logic               in_ready_o;
  logic [XLEN-1:0]    in_data_i;
  // Y word stream out of the host
  logic               out_valid_o;
  logic               out_ready_i;
  logic [XLEN-1:0]    out_data_o;
  logic               out_last_o;
  // status
  logic               busy_o;
  logic               done_o;
  logic               err_o;
  // register-map bus (read data is combinational, same cycle as en_o)
  logic               en_o;
  logic [3:0]         we_o;
  logic [ADDRLEN-1:0] addr_o;
  logic [XLEN-1:0]    wrdata_o;
  logic [XLEN-1:0]    rddata_i;

  modport slave (
    input  cmd_valid_i, cmd_l_i, in_valid_i, in_data_i, out_ready_i, rddata_i,
    output cmd_ready_o, in_ready_o, out_valid_o, out_data_o, out_last_o,
           busy_o, done_o, err_o, en_o, we_o, addr_o, wrdata_o
  );

  modport master (
    output cmd_valid_i, cmd_l_i, in_valid_i, in_data_i, out_ready_i, rddata_i,
    input  cmd_ready_o, in_ready_o, out_valid_o, out_data_o, out_last_o,
           busy_o, done_o, err_o, en_o, we_o, addr_o, wrdata_o
  );
endinterface

// File: rtl/bash_hash_host.sv
// Purpose : sequences one bash hash on a register-mapped engine. It writes 32 X words, then L, PREP and START, polls for completion and streams out 16 Y words.
// Latency : one bus access per cycle. X writes follow in_valid. A Y word is registered on the edge that reads it.
// Backpress: in_ready only in LOAD_X. Y reads stall while out_valid is held by out_ready=0. A poll timeout sets err_o and returns to IDLE.
// Ports   : clk_i, rst_i (sync, active-high), io (bash_hash_host_if.slave: cmd / in / out streams, busy/done/err, en/we/addr/wrdata/rddata).
package bash_hash_params_pkg;
  localparam int XLEN    = 32;
  localparam int ADDRLEN = 8;

  // Engine register map. X occupies 0x00..0x7C and Y occupies 0x80..0xBC.
  localparam logic [ADDRLEN-1:0] Y_BASE          = 8'h80;
  localparam logic [ADDRLEN-1:0] L_ADDR          = 8'hC0;
  localparam logic [ADDRLEN-1:0] PREP_ADDR       = 8'hC4;
  localparam logic [ADDRLEN-1:0] START_ADDR      = 8'hC8;
  localparam logic [ADDRLEN-1:0] RDY_ACTIVE_ADDR = 8'hCC;
endpackage

module bash_hash_host
  import bash_hash_params_pkg::*;
#(
  parameter int POLL_TIMEOUT = 4096
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  bash_hash_host_if.slave       io
);

  localparam int CW = $clog2(POLL_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, LOAD_X, WR_L, PREP, START, POLL, READ_Y
  } state_t;

  state_t            state_q;
  logic [4:0]        idx_q;        // X word index (0..31) or Y word index (0..16)
  logic [CW-1:0]     cnt_q;        // POLL cycle counter
  logic [XLEN-1:0]   l_q;
  logic [XLEN-1:0]   out_data_q;
  logic              out_valid_q;
  logic              out_last_q;
  logic              done_q;
  logic              err_q;

  logic              stat_rdy;
  logic              stat_active;
  logic              out_hs;
  logic              y_rd_go;

  assign stat_rdy    = io.rddata_i[0];
  assign stat_active = io.rddata_i[XLEN/2];
  assign out_hs      = out_valid_q && io.out_ready_i;
  // Read the next Y word only when the output register is free or being emptied this cycle.
  assign y_rd_go     = (state_q == READ_Y) && !idx_q[4] && (!out_valid_q || io.out_ready_i);

  // Register-map bus decode. rst_i gates the strobe so that no access escapes
  // in the cycle when a mid-operation reset is applied.
  always_comb begin
    io.en_o     = 1'b0;
    io.we_o     = 4'h0;
    io.addr_o   = '0;
    io.wrdata_o = '0;
    case (state_q)
      LOAD_X: begin
        if (io.in_valid_i) begin
          io.en_o     = 1'b1;
          io.we_o     = 4'hF;
          io.addr_o   = ADDRLEN'({idx_q, 2'b00});
          io.wrdata_o = io.in_data_i;
        end
      end
      WR_L: begin
        io.en_o     = 1'b1;
        io.we_o     = 4'hF;
        io.addr_o   = L_ADDR;
        io.wrdata_o = l_q;
      end
      PREP: begin
        io.en_o   = 1'b1;
        io.we_o   = 4'hF;
        io.addr_o = PREP_ADDR;
      end
      START: begin
        io.en_o   = 1'b1;
        io.we_o   = 4'hF;
        io.addr_o = START_ADDR;
      end
      POLL: begin
        io.en_o   = 1'b1;
        io.addr_o = RDY_ACTIVE_ADDR;
      end
      READ_Y: begin
        if (y_rd_go) begin
          io.en_o   = 1'b1;
          io.addr_o = Y_BASE | ADDRLEN'({idx_q[3:0], 2'b00});
        end
      end
      default: ;
    endcase
    if (rst_i) begin
      io.en_o = 1'b0;
      io.we_o = 4'h0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      l_q         <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (io.cmd_valid_i) begin
            l_q     <= io.cmd_l_i;
            err_q   <= 1'b0;
            idx_q   <= '0;
            state_q <= LOAD_X;
          end
        end
        LOAD_X: begin
          if (io.in_valid_i) begin
            if (idx_q == 5'd31) begin
              idx_q   <= '0;
              state_q <= WR_L;
            end else begin
              idx_q <= idx_q + 5'd1;
            end
          end
        end
        WR_L:  state_q <= PREP;
        PREP:  state_q <= START;
        START: begin
          cnt_q   <= '0;
          state_q <= POLL;
        end
        POLL: begin
          // The status read on the first POLL cycle may still reflect the
          // previous hash, so completion is only trusted from cycle two.
          if ((cnt_q != '0) && stat_rdy && !stat_active) begin
            idx_q   <= '0;
            state_q <= READ_Y;
          end else if (cnt_q == CW'(POLL_TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        READ_Y: begin
          if (out_hs) begin
            out_valid_q <= 1'b0;
          end
          if (y_rd_go) begin
            out_data_q  <= io.rddata_i;
            out_valid_q <= 1'b1;
            out_last_q  <= (idx_q == 5'd15);
            idx_q       <= idx_q + 5'd1;
          end
          if (out_hs && out_last_q) begin
            out_last_q <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign io.cmd_ready_o = (state_q == IDLE);
  assign io.busy_o      = (state_q != IDLE);
  assign io.in_ready_o  = (state_q == LOAD_X) && !rst_i;
  assign io.out_valid_o = out_valid_q;
  assign io.out_data_o  = out_data_q;
  assign io.out_last_o  = out_last_q;
  assign io.done_o      = done_q;
  assign io.err_o       = err_q;

endmodule

// File: tb/tb_bash_hash_host.sv
// Purpose : bench for bash_hash_host. A register-mapped engine model sits on the bus, and scoreboards hold the expected bus writes and Y words.
// Latency : inputs are driven 1 time unit after posedge. The monitor samples on negedge.
// Backpress: out_ready runs in one of three modes: always-1, a 1,0,0 pattern, or random.
module tb_bash_hash_host;
  import bash_hash_params_pkg::*;

  localparam int PT = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bash_hash_host_if #(.XLEN(XLEN), .ADDRLEN(ADDRLEN)) io ();

  bash_hash_host #(.POLL_TIMEOUT(PT)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .io    (io)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // The engine's Y output is a fixed mixing function of the X words and L.
  function automatic logic [31:0] yfun(input int i, input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] l);
    return a ^ {b[15:0], b[31:16]} ^ l ^ (32'(i) * 32'h9E3779B9);
  endfunction

  // ---------------- engine model on the register bus ----------------
  logic [31:0] mem_x [32];
  logic [31:0] reg_l;
  int          tmr;
  bit          armed;
  bit          stale_q;
  int          delay_cfg;   // -1: never completes
  bit          stale_cfg;
  logic        hw_done;

  assign hw_done = armed && (tmr == 0);

  always @(posedge clk) begin
    if (rst) begin
      armed   <= 1'b0;
      stale_q <= 1'b0;
      tmr     <= 0;
    end else begin
      if (tmr > 0) tmr <= tmr - 1;
      if (io.en_o && io.we_o == 4'hF) begin
        if (!io.addr_o[7]) mem_x[io.addr_o[6:2]] <= io.wrdata_o;
        else if (io.addr_o == L_ADDR) reg_l <= io.wrdata_o;
        else if (io.addr_o == START_ADDR) begin
          armed   <= (delay_cfg >= 0);
          tmr     <= (delay_cfg >= 0) ? delay_cfg : 0;
          stale_q <= stale_cfg;
        end
      end
      if (io.en_o && io.we_o == 4'h0 && io.addr_o == RDY_ACTIVE_ADDR) stale_q <= 1'b0;
    end
  end

  always_comb begin
    int yi;
    yi = int'(io.addr_o[5:2]);
    io.rddata_i = '0;
    if (io.addr_o == RDY_ACTIVE_ADDR) begin
      if (stale_q || hw_done) io.rddata_i = 32'h0000_0001;
      else                    io.rddata_i = 32'h0001_0000;
    end else if (io.addr_o[7:6] == 2'b10) begin
      io.rddata_i = yfun(yi, mem_x[2*yi], mem_x[2*yi+1], reg_l);
    end
  end

  // ---------------- scoreboards and monitor ----------------
  logic [39:0] wr_q [$];    // {addr, data} of expected bus writes, in order
  logic [32:0] exp_q [$];   // {last, data} of expected Y words, in order
  int   n_poll = 0, n_yrd = 0, n_yacc = 0, n_done = 0;
  int   y_idx = 0;
  bit   hold_v = 1'b0;
  logic [32:0] held, e33;
  logic [39:0] e40;

  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (io.cmd_valid_i && io.cmd_ready_o) y_idx = 0;
      if (!io.en_o) chk("we_idle", io.we_o, 4'h0);
      if (io.en_o && io.we_o != 4'h0) begin
        if (wr_q.size() == 0) chk("unexpected_write", {io.addr_o, io.wrdata_o}, 0);
        else begin
          e40 = wr_q.pop_front();
          chk("bus_write", {io.addr_o, io.wrdata_o}, e40);
        end
      end else if (io.en_o) begin
        if (io.addr_o == RDY_ACTIVE_ADDR) n_poll++;
        else begin
          chk("y_rd_addr", io.addr_o, 8'h80 + 8'(4 * y_idx));
          chk("y_rd_after_ready", hw_done, 1);
          y_idx++;
          n_yrd++;
        end
      end
      if (io.out_valid_o) begin
        if (hold_v) chk("stall_stable", {io.out_last_o, io.out_data_o}, held);
        if (io.out_ready_i) begin
          if (exp_q.size() == 0) chk("unexpected_y", {io.out_last_o, io.out_data_o}, 0);
          else begin
            e33 = exp_q.pop_front();
            chk("y_word", {io.out_last_o, io.out_data_o}, e33);
          end
          n_yacc++;
          hold_v = 1'b0;
        end else begin
          hold_v = 1'b1;
          held   = {io.out_last_o, io.out_data_o};
        end
      end else begin
        if (hold_v) chk("stall_valid_drop", 0, 1);
        hold_v = 1'b0;
      end
      if (io.done_o) n_done++;
    end
  end

  // ---------------- out_ready driver ----------------
  int rmode = 0;
  initial begin
    int ph;
    ph = 0;
    io.out_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0:       io.out_ready_i = 1'b1;
        1:       io.out_ready_i = (ph % 3 == 0);
        default: io.out_ready_i = 1'($urandom_range(0, 1));
      endcase
      ph++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_abort();
    io.in_valid_i  = 1'b0;
    io.cmd_valid_i = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", io.out_valid_o, 0);
    chk("rst_out_last",  io.out_last_o, 0);
    chk("rst_done",      io.done_o, 0);
    chk("rst_err",       io.err_o, 0);
    chk("rst_busy",      io.busy_o, 0);
    chk("rst_en",        io.en_o, 0);
    chk("rst_we",        io.we_o, 0);
    chk("rst_cmd_ready", io.cmd_ready_o, 1);
    chk("rst_in_ready",  io.in_ready_o, 0);
    wr_q.delete();
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run_hash(input logic [31:0] l, input int dly, input bit gap, input bit stale,
                          input bit exp_to, input bit rand_x, input int abort_x, input int abort_y);
    logic [31:0] x [32];
    int p0, y0, d0, a0;
    bit fin;
    for (int i = 0; i < 32; i++) x[i] = rand_x ? $urandom : 32'(i + 1);
    for (int i = 0; i < 32; i++) wr_q.push_back({8'(i * 4), x[i]});
    wr_q.push_back({L_ADDR, l});
    wr_q.push_back({PREP_ADDR, 32'h0});
    wr_q.push_back({START_ADDR, 32'h0});
    if (!exp_to)
      for (int i = 0; i < 16; i++) exp_q.push_back({(i == 15), yfun(i, x[2*i], x[2*i+1], l)});
    delay_cfg = dly;
    stale_cfg = stale;
    p0 = n_poll; y0 = n_yrd; d0 = n_done; a0 = n_yacc;

    chk("cmd_ready_idle", io.cmd_ready_o, 1);
    io.cmd_valid_i = 1'b1;
    io.cmd_l_i     = l;
    @(posedge clk);
    #1;
    io.cmd_valid_i = 1'b0;
    chk("busy_after_cmd", io.busy_o, 1);
    chk("err_cleared", io.err_o, 0);
    chk("cmd_ready_busy", io.cmd_ready_o, 0);

    for (int i = 0; i < 32; i++) begin
      if (i == abort_x) begin
        do_abort();
        return;
      end
      if (gap) begin
        io.in_valid_i = 1'b0;
        @(posedge clk);
        #1;
      end
      io.in_valid_i = 1'b1;
      io.in_data_i  = x[i];
      @(posedge clk);
      #1;
    end
    io.in_valid_i = 1'b0;

    fin = 1'b0;
    for (int n = 0; n < 3000 && !fin; n++) begin
      @(posedge clk);
      #1;
      if (abort_y >= 0 && (n_yacc - a0) >= abort_y) begin
        do_abort();
        return;
      end
      if (io.done_o || io.err_o) fin = 1'b1;
    end
    chk("finish_within_budget", fin, 1);
    repeat (2) @(posedge clk);
    #1;
    if (exp_to) begin
      chk("timeout_err", io.err_o, 1);
      chk("timeout_poll_cycles", n_poll - p0, PT);
      chk("timeout_no_y_reads", n_yrd - y0, 0);
      chk("timeout_no_done", n_done - d0, 0);
      exp_q.delete();
    end else begin
      chk("y_read_count", n_yrd - y0, 16);
      chk("y_accept_count", n_yacc - a0, 16);
      chk("done_pulses", n_done - d0, 1);
      chk("err_clear", io.err_o, 0);
      chk("y_queue_empty", exp_q.size(), 0);
      if (stale) chk("stale_polls_ge_20", (n_poll - p0) >= 20, 1);
    end
    chk("writes_all_seen", wr_q.size(), 0);
    chk("idle_busy", io.busy_o, 0);
    chk("idle_in_ready", io.in_ready_o, 0);
    chk("idle_out_valid", io.out_valid_o, 0);
  endtask

  initial begin
    rst            = 1'b1;
    io.cmd_valid_i = 1'b0;
    io.cmd_l_i     = '0;
    io.in_valid_i  = 1'b0;
    io.in_data_i   = '0;
    delay_cfg      = 50;
    stale_cfg      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_abort();

    rmode = 0;  run_hash(32'h200, 50, 0, 0, 0, 0, -1, -1);           // full hash
    rmode = 0;  run_hash(32'h200, 50, 1, 0, 0, 0, -1, -1);           // gapped input
    rmode = 1;  run_hash($urandom, 30, 0, 0, 0, 1, -1, -1);          // backpressure
    rmode = 0;  run_hash($urandom, 20, 0, 1, 0, 1, -1, -1);          // stale status
    rmode = 0;  run_hash($urandom, -1, 0, 0, 1, 1, -1, -1);          // poll timeout
    rmode = 2;  run_hash($urandom, 10, 0, 0, 0, 1, -1, -1);          // clears err_o
    rmode = 0;  run_hash(32'h200, 50, 0, 0, 0, 0, 10, -1);           // reset at X word 10
    rmode = 2;  run_hash($urandom, 15, 0, 0, 0, 1, -1, 5);           // reset in READ_Y word 5
    rmode = 0;  run_hash(32'h200, 50, 0, 0, 0, 0, -1, -1);           // fresh command
    for (int k = 0; k < 4; k++) begin
      rmode = int'($urandom_range(0, 2));
      run_hash($urandom, int'($urandom_range(2, 40)), 1'($urandom_range(0, 1)), 0, 0, 1, -1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
